// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR vote monitor: health-state encodings and the
// saturation limit helper for the mismatch counter.
package tmr_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_SUSPECT = 2'b01,
        ST_FAILED  = 2'b10
    } tmr_state_e;

    // Streak counters only need to reach thresholds of at most 255.
    localparam int unsigned STREAK_W = 8;

    function automatic logic [31:0] cnt_sat(input int unsigned width);
        if (width >= 32) begin
            return '1;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/tmr_majority3.sv
// Purely combinational per-bit 2-of-3 majority of three equal-width lanes.
module tmr_majority3 #(
    parameter int unsigned LANE_W = 1
) (
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    input  logic [LANE_W-1:0] c_i,
    output logic [LANE_W-1:0] maj_o
);

    assign maj_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/tmr_vote_monitor.sv
// Votes the three replicated lanes, flags disagreeing lanes and tracks a
// saturating mismatch count plus an OK/SUSPECT/FAILED health state.
module tmr_vote_monitor
    import tmr_pkg::*;
#(
    parameter int unsigned LANE_W         = 1,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned FAIL_THRESH    = 4,
    parameter int unsigned RECOVER_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3*LANE_W-1:0]   q_in,
    input  logic                  valid_in,
    input  logic                  clr,
    output logic [LANE_W-1:0]     voted,
    output logic                  voted_valid,
    output logic [2:0]            lane_err,
    output logic                  mismatch,
    output logic [CNT_W-1:0]      mismatch_count,
    output logic [1:0]            state
);

    localparam logic [CNT_W-1:0]    CntMax  = CNT_W'(cnt_sat(CNT_W));
    localparam logic [STREAK_W-1:0] FailThr = STREAK_W'(FAIL_THRESH);
    localparam logic [STREAK_W-1:0] RecThr  = STREAK_W'(RECOVER_CYCLES);

    logic [LANE_W-1:0] lane0, lane1, lane2, maj;
    logic [2:0]        lane_err_now;
    logic              any_err;

    assign lane0 = q_in[0*LANE_W +: LANE_W];
    assign lane1 = q_in[1*LANE_W +: LANE_W];
    assign lane2 = q_in[2*LANE_W +: LANE_W];

    tmr_majority3 #(
        .LANE_W (LANE_W)
    ) u_majority (
        .a_i   (lane0),
        .b_i   (lane1),
        .c_i   (lane2),
        .maj_o (maj)
    );

    assign lane_err_now = {lane2 != maj, lane1 != maj, lane0 != maj};
    assign any_err      = |lane_err_now;

    logic [LANE_W-1:0] voted_q, voted_d;
    logic              voted_valid_q, voted_valid_d;
    logic [2:0]        lane_err_q, lane_err_d;
    logic              mismatch_q, mismatch_d;

    always_comb begin
        voted_d       = valid_in ? maj : voted_q;
        lane_err_d    = valid_in ? lane_err_now : lane_err_q;
        mismatch_d    = valid_in ? any_err : mismatch_q;
        voted_valid_d = valid_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            voted_q       <= '0;
            voted_valid_q <= 1'b0;
            lane_err_q    <= '0;
            mismatch_q    <= 1'b0;
        end else begin
            voted_q       <= voted_d;
            voted_valid_q <= voted_valid_d;
            lane_err_q    <= lane_err_d;
            mismatch_q    <= mismatch_d;
        end
    end

    tmr_state_e           state_q, state_d;
    logic [STREAK_W-1:0]  fail_streak_q, fail_streak_d;
    logic [STREAK_W-1:0]  clean_streak_q, clean_streak_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STREAK_W-1:0]  fail_inc, clean_inc;

    assign fail_inc  = fail_streak_q + 1'b1;
    assign clean_inc = clean_streak_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_OK;
            fail_streak_q  <= '0;
            clean_streak_q <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            fail_streak_q  <= fail_streak_d;
            clean_streak_q <= clean_streak_d;
            cnt_q          <= cnt_d;
        end
    end

    // clr beats a simultaneous valid sample: that sample is not counted.
    always_comb begin
        state_d        = state_q;
        fail_streak_d  = fail_streak_q;
        clean_streak_d = clean_streak_q;
        cnt_d          = cnt_q;
        if (clr) begin
            state_d        = ST_OK;
            fail_streak_d  = '0;
            clean_streak_d = '0;
            cnt_d          = '0;
        end else if (valid_in) begin
            if (any_err && (cnt_q != CntMax)) begin
                cnt_d = cnt_q + 1'b1;
            end
            case (state_q)
                ST_OK: begin
                    if (any_err) begin
                        fail_streak_d  = STREAK_W'(1);
                        clean_streak_d = '0;
                        state_d        = (FailThr == STREAK_W'(1)) ? ST_FAILED : ST_SUSPECT;
                    end
                end
                ST_SUSPECT: begin
                    if (any_err) begin
                        fail_streak_d  = fail_inc;
                        clean_streak_d = '0;
                        if (fail_inc >= FailThr) begin
                            state_d = ST_FAILED;
                        end
                    end else begin
                        fail_streak_d  = '0;
                        clean_streak_d = clean_inc;
                        if (clean_inc >= RecThr) begin
                            state_d        = ST_OK;
                            clean_streak_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        voted          = voted_q;
        voted_valid    = voted_valid_q;
        lane_err       = lane_err_q;
        mismatch       = mismatch_q;
        mismatch_count = cnt_q;
        state          = state_q;
    end

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Bench for tmr_vote_monitor: directed vector table, hand-written saturation
// sequence and a random phase, all checked against a behavioural model.
module tb_tmr_vote_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clr, valid_in;
    logic [2:0] q_in;

    logic       voted0, vv0, mm0, voted1, vv1, mm1, voted2, vv2, mm2;
    logic [2:0] le0, le1, le2;
    logic [7:0] cnt0, cnt2;
    logic [2:0] cnt1;
    logic [1:0] st0, st1, st2;

    tmr_vote_monitor u_dut0 (
        .clk(clk), .rst(rst), .q_in(q_in), .valid_in(valid_in), .clr(clr),
        .voted(voted0), .voted_valid(vv0), .lane_err(le0), .mismatch(mm0),
        .mismatch_count(cnt0), .state(st0)
    );

    tmr_vote_monitor #(.CNT_W(3)) u_dut1 (
        .clk(clk), .rst(rst), .q_in(q_in), .valid_in(valid_in), .clr(clr),
        .voted(voted1), .voted_valid(vv1), .lane_err(le1), .mismatch(mm1),
        .mismatch_count(cnt1), .state(st1)
    );

    tmr_vote_monitor #(.FAIL_THRESH(1), .RECOVER_CYCLES(3)) u_dut2 (
        .clk(clk), .rst(rst), .q_in(q_in), .valid_in(valid_in), .clr(clr),
        .voted(voted2), .voted_valid(vv2), .lane_err(le2), .mismatch(mm2),
        .mismatch_count(cnt2), .state(st2)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: shared datapath view plus per-instance health tracking.
    int cmax[3] = '{255, 7, 255};
    int fthr[3] = '{4, 4, 1};
    int rec[3]  = '{8, 8, 3};
    int m_cnt[3], m_st[3], m_fs[3], m_cs[3];
    int m_voted, m_lerr, m_mis, m_vv;

    task automatic model_update();
        int ones, vote, errs;
        if (rst) begin
            m_voted = 0; m_lerr = 0; m_mis = 0; m_vv = 0;
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0; m_st[i] = 0; m_fs[i] = 0; m_cs[i] = 0;
            end
            return;
        end
        ones = int'(q_in[0]) + int'(q_in[1]) + int'(q_in[2]);
        vote = (ones >= 2) ? 1 : 0;
        errs = 0;
        for (int k = 0; k < 3; k++) if (int'(q_in[k]) != vote) errs += (1 << k);
        m_vv = valid_in ? 1 : 0;
        if (valid_in) begin
            m_voted = vote; m_lerr = errs; m_mis = (errs != 0) ? 1 : 0;
        end
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                m_cnt[i] = 0; m_st[i] = 0; m_fs[i] = 0; m_cs[i] = 0;
            end else if (valid_in) begin
                if (errs != 0) m_cnt[i] = (m_cnt[i] + 1 > cmax[i]) ? cmax[i] : m_cnt[i] + 1;
                if (m_st[i] == 2) begin
                    // failed is sticky
                end else if (errs != 0) begin
                    m_cs[i] = 0;
                    m_fs[i] = (m_st[i] == 0) ? 1 : m_fs[i] + 1;
                    m_st[i] = (m_fs[i] >= fthr[i]) ? 2 : 1;
                end else if (m_st[i] == 1) begin
                    m_fs[i] = 0;
                    m_cs[i] = m_cs[i] + 1;
                    if (m_cs[i] >= rec[i]) begin
                        m_st[i] = 0; m_cs[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        check("m0_voted", 32'(voted0), 32'(m_voted));
        check("m0_lerr", 32'(le0), 32'(m_lerr));
        check("m0_mis", 32'(mm0), 32'(m_mis));
        check("m0_vv", 32'(vv0), 32'(m_vv));
        check("m0_cnt", 32'(cnt0), 32'(m_cnt[0]));
        check("m0_state", 32'(st0), 32'(m_st[0]));
        check("m1_voted", 32'(voted1), 32'(m_voted));
        check("m1_lerr", 32'(le1), 32'(m_lerr));
        check("m1_cnt", 32'(cnt1), 32'(m_cnt[1]));
        check("m1_state", 32'(st1), 32'(m_st[1]));
        check("m2_lerr", 32'(le2), 32'(m_lerr));
        check("m2_mis", 32'(mm2), 32'(m_mis));
        check("m2_vv", 32'(vv2), 32'(m_vv));
        check("m2_cnt", 32'(cnt2), 32'(m_cnt[2]));
        check("m2_state", 32'(st2), 32'(m_st[2]));
    endtask

    task automatic step(input logic r, input logic c, input logic v, input logic [2:0] q);
        @(negedge clk);
        rst = r; clr = c; valid_in = v; q_in = q;
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic       r, c, v;
        logic [2:0] q;
        logic       voted;
        logic [2:0] lerr;
        logic       mis, vv;
        int         cnt, st;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic c, input logic v, input logic [2:0] q,
                       input logic ev, input logic [2:0] el, input logic em, input logic evv,
                       input int ec, input int es);
        vec_t e;
        e.r = r; e.c = c; e.v = v; e.q = q;
        e.voted = ev; e.lerr = el; e.mis = em; e.vv = evv; e.cnt = ec; e.st = es;
        tbl.push_back(e);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; valid_in = 1'b0; q_in = 3'b000;

        // Reset and idle
        add(1, 0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);
        add(1, 0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);
        add(0, 0, 1, 3'b000, 0, 3'b000, 0, 1, 0, 0);
        // Single-lane fault, then recovery after 8 clean samples
        add(0, 0, 1, 3'b010, 0, 3'b010, 1, 1, 1, 1);
        for (int i = 0; i < 7; i++) add(0, 0, 1, 3'b111, 1, 3'b000, 0, 1, 1, 1);
        add(0, 0, 1, 3'b111, 1, 3'b000, 0, 1, 1, 0);
        // clr with no sample: counter cleared, datapath held
        add(0, 1, 0, 3'b000, 1, 3'b000, 0, 0, 0, 0);
        // Four consecutive lane-0 faults reach FAILED, which is sticky
        add(0, 0, 1, 3'b110, 1, 3'b001, 1, 1, 1, 1);
        add(0, 0, 1, 3'b110, 1, 3'b001, 1, 1, 2, 1);
        add(0, 0, 1, 3'b110, 1, 3'b001, 1, 1, 3, 1);
        add(0, 0, 1, 3'b110, 1, 3'b001, 1, 1, 4, 2);
        add(0, 0, 1, 3'b111, 1, 3'b000, 0, 1, 4, 2);
        add(0, 0, 1, 3'b111, 1, 3'b000, 0, 1, 4, 2);
        // clr with a simultaneous mismatch while FAILED
        add(0, 1, 1, 3'b101, 1, 3'b010, 1, 1, 0, 0);
        add(0, 0, 0, 3'b000, 1, 3'b010, 1, 0, 0, 0);
        // Valid mismatches separated by gaps
        add(0, 0, 1, 3'b011, 1, 3'b100, 1, 1, 1, 1);
        add(0, 0, 0, 3'b000, 1, 3'b100, 1, 0, 1, 1);
        add(0, 0, 1, 3'b011, 1, 3'b100, 1, 1, 2, 1);
        add(0, 0, 0, 3'b111, 1, 3'b100, 1, 0, 2, 1);
        add(0, 0, 1, 3'b011, 1, 3'b100, 1, 1, 3, 1);
        add(0, 0, 0, 3'b000, 1, 3'b100, 1, 0, 3, 1);
        add(0, 0, 1, 3'b011, 1, 3'b100, 1, 1, 4, 2);
        // Reset in the middle of SUSPECT
        add(0, 1, 0, 3'b000, 1, 3'b100, 1, 0, 0, 0);
        add(0, 0, 1, 3'b001, 0, 3'b001, 1, 1, 1, 1);
        add(1, 0, 1, 3'b111, 0, 3'b000, 0, 0, 0, 0);

        foreach (tbl[n]) begin
            step(tbl[n].r, tbl[n].c, tbl[n].v, tbl[n].q);
            check($sformatf("v%0d_voted", n), 32'(voted0), 32'(tbl[n].voted));
            check($sformatf("v%0d_lerr", n), 32'(le0), 32'(tbl[n].lerr));
            check($sformatf("v%0d_mis", n), 32'(mm0), 32'(tbl[n].mis));
            check($sformatf("v%0d_vv", n), 32'(vv0), 32'(tbl[n].vv));
            check($sformatf("v%0d_cnt", n), 32'(cnt0), 32'(tbl[n].cnt));
            check($sformatf("v%0d_state", n), 32'(st0), 32'(tbl[n].st));
            check_model();
        end

        // Saturation: the 3-bit counter stops at 7, the 8-bit one keeps going
        step(0, 1, 0, 3'b000);
        for (int i = 1; i <= 10; i++) begin
            step(0, 0, 1, 3'b100);
            check($sformatf("sat%0d_cnt1", i), 32'(cnt1), (i > 7) ? 32'd7 : 32'(i));
            check($sformatf("sat%0d_cnt0", i), 32'(cnt0), 32'(i));
            check($sformatf("sat%0d_st2", i), 32'(st2), 32'd2);
        end
        check("sat_state1", 32'(st1), 32'd2);
        check_model();

        // Random phase
        step(1, 0, 0, 3'b000);
        check_model();
        for (int i = 0; i < 400; i++) begin
            logic r, c, v;
            logic [2:0] q;
            r = ($urandom_range(0, 99) < 2);
            c = ($urandom_range(0, 99) < 4);
            v = ($urandom_range(0, 99) < 75);
            // Bias toward clean samples so recovery paths get exercised.
            q = ($urandom_range(0, 99) < 60) ? ($urandom_range(0, 1) ? 3'b111 : 3'b000)
                                              : 3'($urandom_range(0, 7));
            step(r, c, v, q);
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
